// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control bundle between the accumulator CPU sequencer and its datapath.
//
// Purpose: carries the decoded opcode and flags into the sequencer, and the PC/IR/memory/
// accumulator strobes out of it.
//   Inputs to the sequencer : Opcode[4:0] (IR[15:11]), Zero, Run, MemReady (optional)
//   Outputs of the sequencer: PCWrite, Branch, bneOrbeq, PCSrc[1:0], IRWrite, MemRead,
//                             MemWrite, AccWrite, ALUOp[1:0], Halted, State[2:0]
// Build option: PC_SEQ_WAIT_STATE_EN adds the MemReady handshake input.
// Modports: master = sequencer side, slave = datapath side.

interface pc_sequencer_if;
    logic [4:0] Opcode;
    logic       Zero;
    logic       Run;
`ifdef PC_SEQ_WAIT_STATE_EN
    logic       MemReady;
`endif
    logic       PCWrite;
    logic       Branch;
    logic       bneOrbeq;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       AccWrite;
    logic [1:0] ALUOp;
    logic       Halted;
    logic [2:0] State;

    modport master (
        output PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite, AccWrite,
        output ALUOp, Halted, State,
`ifdef PC_SEQ_WAIT_STATE_EN
        input  MemReady,
`endif
        input  Opcode, Zero, Run
    );

    modport slave (
        input  PCWrite, Branch, bneOrbeq, PCSrc, IRWrite, MemRead, MemWrite, AccWrite,
        input  ALUOp, Halted, State,
`ifdef PC_SEQ_WAIT_STATE_EN
        output MemReady,
`endif
        output Opcode, Zero, Run
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle control FSM for the accumulator CPU.
//
// Purpose: steps each instruction through FETCH/DECODE/EXEC/MEM/WB, parks in HALT on HALT_OP,
// and drives the PC select/enable, IR, memory and accumulator strobes.
// Ports:
//   CLK   - system clock, rising edge
//   reset - asynchronous active-low reset (0 = in reset)
//   bus   - pc_sequencer_if.master: Opcode/Zero/Run(/MemReady) in, control strobes out
// Build option: define PC_SEQ_WAIT_STATE_EN to stretch FETCH and MEM with MemReady.
// Outputs are decoded from the registered state plus Opcode (and Run in FETCH); Zero is only
// consumed by the PC block through Branch/bneOrbeq, never by this block.

module pc_sequencer #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter logic [4:0] HALT_OP     = 5'b11111
) (
    input logic            CLK,
    input logic            reset,
    pc_sequencer_if.master bus
);

    localparam logic [4:0] OpLoad  = 5'b00000;
    localparam logic [4:0] OpStore = 5'b00001;
    localparam logic [4:0] OpAdd   = 5'b00010;
    localparam logic [4:0] OpSub   = 5'b00011;
    localparam logic [4:0] OpBeq   = 5'b00100;
    localparam logic [4:0] OpBne   = 5'b00101;
    localparam logic [4:0] OpJ     = 5'b00110;
    localparam logic [4:0] OpJr    = 5'b00111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    state_e     r_state;
    state_e     w_next;
    logic       w_mem_ready;
    logic       w_is_mem_op;
    logic       w_is_acc_op;
    logic       w_unused_zero;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_bne_or_beq;
    logic [1:0] w_pc_src;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_acc_write;
    logic [1:0] w_alu_op;
    logic       w_halted;

`ifdef PC_SEQ_WAIT_STATE_EN
    assign w_mem_ready = bus.MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_unused_zero = bus.Zero;

    // LOAD/STORE/ADD/SUB occupy opcodes 0..3; all but STORE write the accumulator.
    assign w_is_mem_op = (bus.Opcode[4:2] == 3'b000);
    assign w_is_acc_op = w_is_mem_op && (bus.Opcode != OpStore);

    always_comb begin
        w_next = r_state;
        case (r_state)
            StFetch:  if (bus.Run && w_mem_ready) w_next = StDecode;
            StDecode: w_next = (bus.Opcode == HALT_OP) ? StHalt : StExec;
            StExec:   w_next = w_is_mem_op ? StMem : StFetch;
            StMem:    if (w_mem_ready) w_next = w_is_acc_op ? StWb : StFetch;
            StWb:     w_next = StFetch;
            StHalt:   w_next = StHalt;
            default:  w_next = StFetch;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= state_e'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_bne_or_beq = 1'b0;
        w_pc_src     = 2'd0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_acc_write  = 1'b0;
        w_alu_op     = 2'd0;
        w_halted     = 1'b0;
        // Gating on reset makes every strobe drop the instant reset asserts, including the
        // FETCH strobes that would otherwise follow Run while the state is held at FETCH.
        if (reset) begin
            case (r_state)
                StFetch: begin
                    if (bus.Run) begin
                        w_mem_read = 1'b1;
                        w_ir_write = 1'b1;
                        // PC advances only in the cycle the fetch completes.
                        w_pc_write = w_mem_ready;
                    end
                end
                StExec: begin
                    case (bus.Opcode)
                        OpBeq: begin
                            w_branch     = 1'b1;
                            w_bne_or_beq = 1'b1;
                            w_pc_src     = 2'd2;
                            w_alu_op     = 2'd1;
                        end
                        OpBne: begin
                            w_branch = 1'b1;
                            w_pc_src = 2'd2;
                            w_alu_op = 2'd1;
                        end
                        OpJ: begin
                            w_pc_write = 1'b1;
                            w_pc_src   = 2'd1;
                        end
                        OpJr: begin
                            w_pc_write = 1'b1;
                            w_pc_src   = 2'd3;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    if (bus.Opcode == OpStore) begin
                        w_mem_write = w_mem_ready;
                    end else if (w_is_acc_op) begin
                        w_mem_read = 1'b1;
                    end
                end
                StWb: begin
                    if (w_is_acc_op) begin
                        w_acc_write = 1'b1;
                        case (bus.Opcode)
                            OpLoad:  w_alu_op = 2'd2;
                            OpSub:   w_alu_op = 2'd1;
                            OpAdd:   w_alu_op = 2'd0;
                            default: w_alu_op = 2'd0;
                        endcase
                    end
                end
                StHalt:  w_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.PCWrite  = w_pc_write;
    assign bus.Branch   = w_branch;
    assign bus.bneOrbeq = w_bne_or_beq;
    assign bus.PCSrc    = w_pc_src;
    assign bus.IRWrite  = w_ir_write;
    assign bus.MemRead  = w_mem_read;
    assign bus.MemWrite = w_mem_write;
    assign bus.AccWrite = w_acc_write;
    assign bus.ALUOp    = w_alu_op;
    assign bus.Halted   = w_halted;
    assign bus.State    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Output vector layout used in all comparisons:
//   {State[2:0], PCWrite, Branch, bneOrbeq, PCSrc[1:0], IRWrite, MemRead, MemWrite, AccWrite,
//    ALUOp[1:0], Halted}

module tb_pc_sequencer;

    localparam logic [4:0] OpLoad  = 5'b00000;
    localparam logic [4:0] OpStore = 5'b00001;
    localparam logic [4:0] OpAdd   = 5'b00010;
    localparam logic [4:0] OpSub   = 5'b00011;
    localparam logic [4:0] OpBeq   = 5'b00100;
    localparam logic [4:0] OpBne   = 5'b00101;
    localparam logic [4:0] OpJ     = 5'b00110;
    localparam logic [4:0] OpJr    = 5'b00111;
    localparam logic [4:0] OpHalt  = 5'b11111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .CLK   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic        zero;
        logic [14:0] exec;
        int          lat;
        int          mw;
        int          aw;
    } tvec_t;

    tvec_t       tbl[10];
    logic [14:0] exp_q[$];

    function automatic logic [14:0] mk(input logic [2:0] st, input logic pcw, input logic br,
                                       input logic beq, input logic [1:0] src, input logic irw,
                                       input logic mr, input logic mw, input logic aw,
                                       input logic [1:0] alu, input logic h);
        return {st, pcw, br, beq, src, irw, mr, mw, aw, alu, h};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.State, bus.PCWrite, bus.Branch, bus.bneOrbeq, bus.PCSrc, bus.IRWrite,
                bus.MemRead, bus.MemWrite, bus.AccWrite, bus.ALUOp, bus.Halted};
    endfunction

    function automatic logic [14:0] idle_vec(input logic [2:0] st);
        return mk(st, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction

    // Reference model: the per-cycle output sequence of one whole instruction, from FETCH on.
    function automatic void build(input logic [4:0] op);
        exp_q.delete();
        exp_q.push_back(mk(3'd0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0));
        exp_q.push_back(idle_vec(3'd1));
        case (op)
            OpLoad, OpAdd, OpSub: begin
                exp_q.push_back(idle_vec(3'd2));
                exp_q.push_back(mk(3'd3, 0, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0, 0));
                exp_q.push_back(mk(3'd4, 0, 0, 0, 2'd0, 0, 0, 0, 1,
                                   (op == OpLoad) ? 2'd2 : ((op == OpSub) ? 2'd1 : 2'd0), 0));
            end
            OpStore: begin
                exp_q.push_back(idle_vec(3'd2));
                exp_q.push_back(mk(3'd3, 0, 0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 0));
            end
            OpBeq:   exp_q.push_back(mk(3'd2, 0, 1, 1, 2'd2, 0, 0, 0, 0, 2'd1, 0));
            OpBne:   exp_q.push_back(mk(3'd2, 0, 1, 0, 2'd2, 0, 0, 0, 0, 2'd1, 0));
            OpJ:     exp_q.push_back(mk(3'd2, 1, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 0));
            OpJr:    exp_q.push_back(mk(3'd2, 1, 0, 0, 2'd3, 0, 0, 0, 0, 2'd0, 0));
            default: exp_q.push_back(idle_vec(3'd2));
        endcase
    endfunction

    function automatic logic [4:0] pick_op();
        if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(8, 30));
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = dut_vec();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks whatever remains in exp_q, one record per cycle, with Run and Zero randomized
    // (neither may affect an instruction already past FETCH).
    task automatic run_queue(input string name);
        logic [14:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.Run  = 1'($urandom);
            bus.Zero = 1'($urandom);
            #1;
            check(name, e);
            step();
        end
        bus.Run = 1'b1;
    endtask

    task automatic run_tbl(input int idx);
        int lat;
        int mw;
        int aw;
        int both;
        lat  = -1;
        mw   = 0;
        aw   = 0;
        both = 0;
        bus.Run    = 1'b1;
        bus.Opcode = tbl[idx].op;
        bus.Zero   = tbl[idx].zero;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c > 0 && bus.State == 3'd0) begin
                lat = c;
                break;
            end
            if (c == 2) check($sformatf("tbl_exec[%0d]", idx), tbl[idx].exec);
            mw += int'(bus.MemWrite);
            aw += int'(bus.AccWrite);
            if (bus.Branch && bus.PCWrite) both++;
            step();
        end
        check_int($sformatf("tbl_latency[%0d]", idx), lat, tbl[idx].lat);
        check_int($sformatf("tbl_memwrites[%0d]", idx), mw, tbl[idx].mw);
        check_int($sformatf("tbl_accwrites[%0d]", idx), aw, tbl[idx].aw);
        check_int($sformatf("tbl_branch_and_pcwrite[%0d]", idx), both, 0);
    endtask

    initial begin
        logic [4:0] op;
        int         pcw;
        n_checks = 0;
        n_errors = 0;

        tbl[0] = '{OpLoad,  1'b0, idle_vec(3'd2), 5, 0, 1};
        tbl[1] = '{OpStore, 1'b1, idle_vec(3'd2), 4, 1, 0};
        tbl[2] = '{OpAdd,   1'b0, idle_vec(3'd2), 5, 0, 1};
        tbl[3] = '{OpSub,   1'b1, idle_vec(3'd2), 5, 0, 1};
        tbl[4] = '{OpBeq,   1'b1, mk(3'd2, 0, 1, 1, 2'd2, 0, 0, 0, 0, 2'd1, 0), 3, 0, 0};
        tbl[5] = '{OpBne,   1'b1, mk(3'd2, 0, 1, 0, 2'd2, 0, 0, 0, 0, 2'd1, 0), 3, 0, 0};
        tbl[6] = '{OpJ,     1'b0, mk(3'd2, 1, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 0), 3, 0, 0};
        tbl[7] = '{OpJr,    1'b0, mk(3'd2, 1, 0, 0, 2'd3, 0, 0, 0, 0, 2'd0, 0), 3, 0, 0};
        tbl[8] = '{5'b01000, 1'b1, idle_vec(3'd2), 3, 0, 0};
        tbl[9] = '{5'b11110, 1'b0, idle_vec(3'd2), 3, 0, 0};

        rst_n      = 1'b0;
        bus.Run    = 1'b1;
        bus.Opcode = OpLoad;
        bus.Zero   = 1'b0;
`ifdef PC_SEQ_WAIT_STATE_EN
        bus.MemReady = 1'b1;
`endif
        #2;
        check("reset_state", idle_vec(3'd0));
        step();
        step();
        rst_n = 1'b1;

        // Per-opcode table: EXEC outputs, latency, and strobe counts.
        for (int i = 0; i < 10; i++) run_tbl(i);

        // Reset in the middle of ADD's WB cycle.
        bus.Run    = 1'b1;
        bus.Opcode = OpAdd;
        bus.Zero   = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        check("add_wb_before_reset", mk(3'd4, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0));
        rst_n = 1'b0;
        #1;
        check("reset_async_drop", idle_vec(3'd0));
        step();
        step();
        check("reset_held", idle_vec(3'd0));
        rst_n = 1'b1;
        #1;
        check("fetch_after_release", mk(3'd0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0));
        step();
        build(OpAdd);
        void'(exp_q.pop_front());
        run_queue("add_after_release");

        // HALT: parks for good, no strobes, Run/Zero ignored.
        bus.Run    = 1'b1;
        bus.Opcode = OpHalt;
        #1;
        check("halt_fetch", mk(3'd0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0));
        step();
        #1;
        check("halt_decode", idle_vec(3'd1));
        step();
        for (int i = 0; i < 20; i++) begin
            bus.Run  = 1'($urandom);
            bus.Zero = 1'($urandom);
            #1;
            check($sformatf("halt_hold[%0d]", i), mk(3'd7, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1));
            step();
        end
        rst_n = 1'b0;
        #1;
        check("halt_reset", idle_vec(3'd0));
        step();
        rst_n   = 1'b1;
        bus.Run = 1'b0;

        // Run = 0 holds FETCH quietly.
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("run_low_idle[%0d]", i), idle_vec(3'd0));
            step();
        end

`ifdef PC_SEQ_WAIT_STATE_EN
        // Fetch stretched by MemReady: strobes held, PC updated exactly once.
        pcw          = 0;
        bus.Run      = 1'b1;
        bus.Opcode   = OpJ;
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait_fetch[%0d]", i), mk(3'd0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0));
            pcw += int'(bus.PCWrite);
            step();
        end
        bus.MemReady = 1'b1;
        #1;
        check("wait_fetch_done", mk(3'd0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 0));
        pcw += int'(bus.PCWrite);
        step();
        #1;
        pcw += int'(bus.PCWrite);
        check("wait_decode", idle_vec(3'd1));
        step();
        check_int("wait_fetch_pcwrite_pulses", pcw, 1);
        #1;
        check("wait_j_exec", mk(3'd2, 1, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 0));
        step();
`else
        pcw = 0;
`endif

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.Run  = 1'b0;
                bus.Zero = 1'($urandom);
                #1;
                check("rand_idle", idle_vec(3'd0));
                step();
                continue;
            end
            op = pick_op();
            build(op);
            bus.Opcode = op;
            bus.Run    = 1'b1;
            bus.Zero   = 1'($urandom);
            #1;
            check($sformatf("rand_fetch op=%b", op), exp_q.pop_front());
            step();
            run_queue($sformatf("rand op=%b", op));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
